// File: rtl/float_to_fixed.sv
// Two-stage single-precision float to signed fixed-point converter with valid/ready flow control.
// Define FTOF_SAT_EN to saturate overflowed results; otherwise overflowed results read as zero.
module float_to_fixed #(
    parameter int FRAC_BITS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf
);

    // Folds the exponent bias, the 23-bit mantissa position and the fractional bits into one offset.
    localparam logic signed [10:0] C_SHIFT_OFS = 11'(FRAC_BITS - 150);

    logic               r_s1_valid;
    logic               r_s1_sign;
    logic [23:0]        r_s1_sig;
    logic signed [10:0] r_s1_shift;
    logic               r_s1_zero;
    logic               r_s1_inf;
    logic               r_s1_frac_nz;

    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic               r_out_ovf;

    logic [7:0]         w_exp;
    logic signed [10:0] w_in_shift;
    logic               w_advance;
    logic signed [10:0] w_neg_shift;
    logic [31:0]        w_sig_ext;
    logic [31:0]        w_mag;
    logic               w_ovf;
    logic [31:0]        w_result;

    assign w_exp      = in_data[30:23];
    assign w_in_shift = $signed({3'b000, w_exp}) + C_SHIFT_OFS;

    // The whole pipeline moves together; it only freezes while a result waits on the consumer.
    assign w_advance  = !(r_out_valid && !out_ready);
    assign in_ready   = w_advance;

    assign w_neg_shift = -r_s1_shift;
    assign w_sig_ext   = {8'h00, r_s1_sig};

    always_comb begin
        w_mag = '0;
        w_ovf = 1'b0;
        if (r_s1_zero) begin
            w_mag = '0;
        end else if (r_s1_inf) begin
            w_ovf = 1'b1;
        end else if (r_s1_shift > 11'sd8) begin
            w_ovf = 1'b1;
        end else if (r_s1_shift >= 11'sd0) begin
            // At a shift of 8 only exactly -2^31 still fits.
            w_mag = w_sig_ext << r_s1_shift[3:0];
            w_ovf = (r_s1_shift == 11'sd8) && (!r_s1_sign || r_s1_frac_nz);
        end else if (w_neg_shift < 11'sd24) begin
            w_mag = w_sig_ext >> w_neg_shift[4:0];
        end
    end

    always_comb begin
        w_result = '0;
        if (w_ovf) begin
`ifdef FTOF_SAT_EN
            w_result = r_s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
            w_result = '0;
`endif
        end else begin
            w_result = r_s1_sign ? (~w_mag + 32'd1) : w_mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_sig     <= '0;
            r_s1_shift   <= '0;
            r_s1_zero    <= 1'b0;
            r_s1_inf     <= 1'b0;
            r_s1_frac_nz <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ovf    <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid  <= in_valid;
            r_out_valid <= r_s1_valid;
            if (in_valid) begin
                r_s1_sign    <= in_data[31];
                r_s1_sig     <= {1'b1, in_data[22:0]};
                r_s1_shift   <= w_in_shift;
                r_s1_zero    <= (w_exp == 8'h00);
                r_s1_inf     <= (w_exp == 8'hFF);
                r_s1_frac_nz <= (in_data[22:0] != 23'd0);
            end
            if (r_s1_valid) begin
                r_out_data <= w_result;
                r_out_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
